// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding and oversampling tick positions.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int CNT_W      = $clog2(OVERSAMPLE);
  localparam int MID_TICK   = OVERSAMPLE / 2 - 1;
  localparam int LAST_TICK  = OVERSAMPLE - 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  // Tick-counter value at which a bit is sampled in the given state.
  function automatic int sample_tick(input state_t st, input int os);
    if (st == ST_START) begin
      return os / 2 - 1;
    end else begin
      return os - 1;
    end
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RESET_VAL is the level the output shows while in reset (idle level of the line).
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability filter: two back-to-back flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver driven by a 16x oversampling tick: start detection, mid-bit sampling,
// stop check and a single-entry valid/ready holding register with overrun reporting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int               CW       = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    MID      = CW'(sample_tick(ST_START, OVERSAMPLE));
  localparam logic [CW-1:0]    LAST     = CW'(sample_tick(ST_DATA, OVERSAMPLE));
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rxd_sync_s;
  logic                 complete_s;

  logic                 prev_q,  prev_d;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q,   cnt_d;
  logic [2:0]           idx_q,   idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q,  ferr_d;
  logic                 ovr_q,   ovr_d;

  uart_sync #(
    .RESET_VAL (1'b1)
  ) u_rxd_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rxd),
    .q_o   (rxd_sync_s)
  );

  // Frame FSM; prev_q holds the synced line at the previous tick so a held-low line never re-triggers.
  always_comb begin
    prev_d     = prev_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    complete_s = 1'b0;
    if (rx_tick) begin
      prev_d = rxd_sync_s;
      case (state_q)
        ST_IDLE: begin
          if (prev_q && !rxd_sync_s) begin
            state_d = ST_START;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (cnt_q == MID) begin
            cnt_d   = CNT_ZERO;
            idx_d   = 3'd0;
            state_d = rxd_sync_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_q == LAST) begin
            cnt_d   = CNT_ZERO;
            shift_d = {rxd_sync_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == LAST_BIT) begin
              idx_d   = 3'd0;
              state_d = ST_STOP;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_q == LAST) begin
            cnt_d      = CNT_ZERO;
            state_d    = ST_IDLE;
            complete_s = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          idx_d   = 3'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Holding register: a completing byte may replace one being drained in the same cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
    if (complete_s) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        ferr_d  = !rxd_sync_s;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= 3'd0;
      shift_q <= {DATA_BITS{1'b0}};
      data_q  <= {DATA_BITS{1'b0}};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: rx_tick every 4 clk, 64 clk per bit, frames phase-aligned to the tick.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       rx_tick;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [8:0] acc_q[$];
  int  valid_cycles = 0;
  int  ovr_cycles   = 0;
  int  ovr_rises    = 0;
  logic ovr_prev    = 1'b0;

  logic       snap_valid;
  logic [7:0] snap_data;
  logic       snap_ferr;
  logic       snap_ovr;

  uart_rx dut (
    .clk       (clk),
    .reset     (reset),
    .rx_tick   (rx_tick),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe the host side just after each falling edge: record handshakes and pulse widths.
  always begin
    @(negedge clk);
    #1;
    if (rx_valid && rx_ready) acc_q.push_back({frame_err, rx_data});
    if (rx_valid) valid_cycles++;
    if (overrun) ovr_cycles++;
    if (overrun && !ovr_prev) ovr_rises++;
    ovr_prev = overrun;
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    rx_tick = ((cyc % 4) == 0);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) step();
  endtask

  function automatic logic [8:0] get_acc(input int i);
    if (i >= 0 && i < acc_q.size()) return acc_q[i];
    else return 9'h1FF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One frame: start, LSB-first data, stop. rdy_off pulses rx_ready for one cycle,
  // rst_off pulses reset low for 5 cycles; both are cycle offsets from the start edge.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int rdy_off, input int rst_off);
    int b;
    while ((cyc % 4) != 1) step();
    for (int o = 0; o < 640; o++) begin
      b = o / 64;
      if (b == 0) rxd = 1'b0;
      else if (b == 9) rxd = stop;
      else rxd = d[b-1];
      if (rdy_off >= 0 && o == rdy_off) rx_ready = 1'b1;
      if (rdy_off >= 0 && o == rdy_off + 1) rx_ready = 1'b0;
      if (rst_off >= 0 && o == rst_off) reset = 1'b0;
      if (rst_off >= 0 && o == rst_off + 3) begin
        snap_valid = rx_valid;
        snap_data  = rx_data;
        snap_ferr  = frame_err;
        snap_ovr   = overrun;
      end
      if (rst_off >= 0 && o == rst_off + 5) reset = 1'b1;
      step();
    end
  endtask

  initial begin
    int o0;
    int oc0;
    int v0;
    reset    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    rx_tick  = 1'b0;
    snap_valid = 1'b1;
    snap_data  = 8'hFF;
    snap_ferr  = 1'b1;
    snap_ovr   = 1'b1;

    repeat (6) step();
    chk("reset_valid", 32'(rx_valid), 32'h0);
    chk("reset_data", 32'(rx_data), 32'h0);
    chk("reset_ferr", 32'(frame_err), 32'h0);
    chk("reset_ovr", 32'(overrun), 32'h0);
    reset = 1'b1;
    idle(64);

    // Two clean bytes with the consumer always ready.
    v0 = valid_cycles;
    send_byte(8'h55, 1'b1, -1, -1);
    idle(64);
    send_byte(8'hA3, 1'b1, -1, -1);
    idle(64);
    chk("t1_count", 32'(acc_q.size()), 32'd2);
    chk("t1_byte0", 32'(get_acc(0)), 32'h055);
    chk("t1_byte1", 32'(get_acc(1)), 32'h0A3);
    chk("t1_valid_cycles", 32'(valid_cycles - v0), 32'd2);

    // 4-tick glitch on idle line.
    while ((cyc % 4) != 1) step();
    rxd = 1'b0;
    repeat (16) step();
    idle(200);
    chk("t2_count", 32'(acc_q.size()), 32'd2);
    chk("t2_valid", 32'(rx_valid), 32'h0);

    // Bad stop bit followed by a 40-bit-time break.
    send_byte(8'h3C, 1'b0, -1, -1);
    repeat (2560) step();
    chk("t3_count", 32'(acc_q.size()), 32'd3);
    chk("t3_byte", 32'(get_acc(2)), 32'h13C);
    idle(128);
    chk("t3_no_restart", 32'(acc_q.size()), 32'd3);
    send_byte(8'h96, 1'b1, -1, -1);
    idle(64);
    chk("t3_recover_count", 32'(acc_q.size()), 32'd4);
    chk("t3_recover_byte", 32'(get_acc(3)), 32'h096);

    // Overrun with consumer stalled.
    rx_ready = 1'b0;
    o0  = ovr_rises;
    oc0 = ovr_cycles;
    send_byte(8'h11, 1'b1, -1, -1);
    idle(64);
    send_byte(8'h22, 1'b1, -1, -1);
    idle(64);
    chk("t4_valid", 32'(rx_valid), 32'h1);
    chk("t4_data", 32'(rx_data), 32'h11);
    chk("t4_ferr", 32'(frame_err), 32'h0);
    chk("t4_ovr_pulses", 32'(ovr_rises - o0), 32'd1);
    chk("t4_ovr_width", 32'(ovr_cycles - oc0), 32'd1);
    chk("t4_count", 32'(acc_q.size()), 32'd4);
    rx_ready = 1'b1;
    step();
    step();
    rx_ready = 1'b0;
    chk("t4_drain_count", 32'(acc_q.size()), 32'd5);
    chk("t4_drain_byte", 32'(get_acc(4)), 32'h011);
    chk("t4_drain_valid", 32'(rx_valid), 32'h0);

    // Drain exactly in the completion cycle of the next byte (stop sample at offset 611).
    send_byte(8'h44, 1'b1, -1, -1);
    idle(64);
    o0 = ovr_rises;
    send_byte(8'h22, 1'b1, 611, -1);
    idle(64);
    chk("t5_valid", 32'(rx_valid), 32'h1);
    chk("t5_data", 32'(rx_data), 32'h22);
    chk("t5_no_ovr", 32'(ovr_rises - o0), 32'd0);
    chk("t5_count", 32'(acc_q.size()), 32'd6);
    chk("t5_drained", 32'(get_acc(5)), 32'h044);

    // Reset during the high data bits of 0xF0, then a clean 0x0F.
    send_byte(8'hF0, 1'b1, -1, 394);
    idle(64);
    chk("t6_rst_valid", 32'(snap_valid), 32'h0);
    chk("t6_rst_data", 32'(snap_data), 32'h0);
    chk("t6_rst_ferr", 32'(snap_ferr), 32'h0);
    chk("t6_rst_ovr", 32'(snap_ovr), 32'h0);
    chk("t6_after_valid", 32'(rx_valid), 32'h0);
    chk("t6_after_count", 32'(acc_q.size()), 32'd6);
    rx_ready = 1'b1;
    send_byte(8'h0F, 1'b1, -1, -1);
    idle(64);
    chk("t6_count", 32'(acc_q.size()), 32'd7);
    chk("t6_byte", 32'(get_acc(6)), 32'h00F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
